// File: rtl/mlp_argmax_if.sv
// Handshake/result bundle between the layer-2 controller and the argmax stage.
// ARGMAX_RUNNER_UP_EN adds the runner-up result signals.
interface mlp_argmax_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_NODES = 387
);
  localparam int IDX_W = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;

  logic                             start;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc;
  logic                             busy;
  logic                             valid;
  logic [IDX_W-1:0]                 max_index;
  logic [DATA_WIDTH-1:0]            max_value;
`ifdef ARGMAX_RUNNER_UP_EN
  logic [IDX_W-1:0]                 second_index;
  logic [DATA_WIDTH-1:0]            second_value;

  modport master (output start, output_fc,
                  input  busy, valid, max_index, max_value, second_index, second_value);
  modport slave  (input  start, output_fc,
                  output busy, valid, max_index, max_value, second_index, second_value);
`else
  modport master (output start, output_fc,
                  input  busy, valid, max_index, max_value);
  modport slave  (input  start, output_fc,
                  output busy, valid, max_index, max_value);
`endif
endinterface

// File: rtl/mlp_argmax.sv
// Argmax over the layer-2 score vector: wait, capture, scan one element per cycle.
// Optional runner-up tracking enabled by defining ARGMAX_RUNNER_UP_EN.
//
// state  | meaning
// S_IDLE | no run since reset
// S_WAIT | down-counting until the PE accumulators have settled
// S_SCAN | comparing captured element idx against the running best
// S_DONE | result presented, valid held until the next start
module mlp_argmax #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_NODES = 387,
  parameter int ACC_CYCLES   = 130
) (
  input  logic       clk,
  input  logic       reset,
  mlp_argmax_if.slave bus
);
  localparam int IDX_W = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1;
  localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] fc_q [OUTPUT_NODES];

  logic [DATA_WIDTH-1:0] best_key, best_val;
  logic [IDX_W-1:0]      best_idx;

  logic [DATA_WIDTH-1:0] elem, elem_key;
  logic                  first, last, take_best;
  logic [DATA_WIDTH-1:0] nb_key, nb_val;
  logic [IDX_W-1:0]      nb_idx;

`ifdef ARGMAX_RUNNER_UP_EN
  logic [DATA_WIDTH-1:0] sec_key, sec_val, ns_key, ns_val;
  logic [IDX_W-1:0]      sec_idx, ns_idx;
  logic                  sec_vld, ns_vld;
`endif

  // Monotonic unsigned key: both zeros collapse to the midpoint, negatives invert.
  function automatic logic [DATA_WIDTH-1:0] key_of(input logic [DATA_WIDTH-1:0] b);
    if (b[DATA_WIDTH-2:0] == '0)
      key_of = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else if (!b[DATA_WIDTH-1])
      key_of = {1'b1, b[DATA_WIDTH-2:0]};
    else
      key_of = ~b;
  endfunction

  always_comb begin
    elem      = fc_q[idx];
    elem_key  = key_of(elem);
    first     = (idx == '0);
    last      = (idx == IDX_W'(OUTPUT_NODES - 1));
    take_best = first || (elem_key > best_key);
    nb_key    = best_key;
    nb_val    = best_val;
    nb_idx    = best_idx;
    if (take_best) begin
      nb_key = elem_key;
      nb_val = elem;
      nb_idx = idx;
    end
`ifdef ARGMAX_RUNNER_UP_EN
    ns_key = sec_key;
    ns_val = sec_val;
    ns_idx = sec_idx;
    ns_vld = sec_vld;
    if (first) begin
      ns_key = '0;
      ns_val = '0;
      ns_idx = '0;
      ns_vld = 1'b0;
    end else if (take_best) begin
      ns_key = best_key;
      ns_val = best_val;
      ns_idx = best_idx;
      ns_vld = 1'b1;
    end else if (!sec_vld || (elem_key > sec_key)) begin
      ns_key = elem_key;
      ns_val = elem;
      ns_idx = idx;
      ns_vld = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      best_key      <= '0;
      best_val      <= '0;
      best_idx      <= '0;
      bus.busy      <= 1'b0;
      bus.valid     <= 1'b0;
      bus.max_index <= '0;
      bus.max_value <= '0;
      for (int k = 0; k < OUTPUT_NODES; k++) fc_q[k] <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
      sec_key          <= '0;
      sec_val          <= '0;
      sec_idx          <= '0;
      sec_vld          <= 1'b0;
      bus.second_index <= '0;
      bus.second_value <= '0;
`endif
    end else if (bus.start) begin
      // Restart from any state; a start on the finishing edge wins over completion.
      state     <= S_WAIT;
      cnt       <= CNT_W'(ACC_CYCLES - 1);
      idx       <= '0;
      bus.busy  <= 1'b1;
      bus.valid <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            for (int k = 0; k < OUTPUT_NODES; k++)
              fc_q[k] <= bus.output_fc[DATA_WIDTH*k +: DATA_WIDTH];
            idx   <= '0;
            state <= S_SCAN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SCAN: begin
          best_key <= nb_key;
          best_val <= nb_val;
          best_idx <= nb_idx;
`ifdef ARGMAX_RUNNER_UP_EN
          sec_key <= ns_key;
          sec_val <= ns_val;
          sec_idx <= ns_idx;
          sec_vld <= ns_vld;
`endif
          if (last) begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.valid     <= 1'b1;
            bus.max_index <= nb_idx;
            bus.max_value <= nb_val;
`ifdef ARGMAX_RUNNER_UP_EN
            bus.second_index <= ns_idx;
            bus.second_value <= ns_val;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_argmax.sv
// Scoreboard bench for mlp_argmax with 4 scores and a 3-cycle accumulate wait.
module tb_mlp_argmax;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int AC = 3;
  localparam int LAT = AC + N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic v_prev = 1'b0;

  typedef struct {
    int cyc;
    int idx;
    int val;
    int sidx;
    int sval;
  } exp_t;
  exp_t exp_q[$];

  mlp_argmax_if #(.DATA_WIDTH(DW), .OUTPUT_NODES(N)) bus ();

  mlp_argmax #(.DATA_WIDTH(DW), .OUTPUT_NODES(N), .ACC_CYCLES(AC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid rising edge.
  always @(negedge clk) begin
    if (bus.valid && !v_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(bus.valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("latency", 32'(cyc), 32'(e.cyc));
        check("max_index", 32'(bus.max_index), 32'(e.idx));
        check("max_value", 32'(bus.max_value), 32'(e.val));
        check("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef ARGMAX_RUNNER_UP_EN
        check("second_index", 32'(bus.second_index), 32'(e.sidx));
        check("second_value", 32'(bus.second_value), 32'(e.sval));
`endif
      end
    end
    v_prev <= bus.valid;
  end

  task automatic set_vec(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    bus.output_fc = {d, c, b, a};
  endtask

  task automatic pulse_start(output int s);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    s = cyc;
  endtask

  task automatic push_exp(input int c, input int i, input int v, input int si, input int sv);
    exp_t e;
    e.cyc = c; e.idx = i; e.val = v; e.sidx = si; e.sval = sv;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid), 32'd0);
    check({tag, "_max_index"}, 32'(bus.max_index), 32'd0);
    check({tag, "_max_value"}, 32'(bus.max_value), 32'd0);
`ifdef ARGMAX_RUNNER_UP_EN
    check({tag, "_second_index"}, 32'(bus.second_index), 32'd0);
    check({tag, "_second_value"}, 32'(bus.second_value), 32'd0);
`endif
  endtask

  initial begin
    int s, s2;
    bus.start = 1'b0;
    bus.output_fc = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Mixed signs: best 0x40 at 1, runner-up 0x38 at 0
    set_vec(8'h38, 8'h40, 8'hC0, 8'h30);
    pulse_start(s);
    push_exp(s + LAT, 1, 8'h40, 0, 8'h38);
    for (int k = 0; k < LAT; k++) begin
      check("busy_during_run", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // All negative, tie at 0xB8 resolves to lowest index
    set_vec(8'hC0, 8'hB8, 8'hC8, 8'hB8);
    pulse_start(s);
    push_exp(s + LAT, 1, 8'hB8, 3, 8'hB8);
    @(negedge clk);
    check("hold_index_while_busy", 32'(bus.max_index), 32'd1);
    check("hold_value_while_busy", 32'(bus.max_value), 32'h40);
    check("valid_cleared_by_start", 32'(bus.valid), 32'd0);
    repeat (LAT + 1) @(negedge clk);

    // Signed zeros compare equal
    set_vec(8'h80, 8'h00, 8'h80, 8'hB8);
    pulse_start(s);
    push_exp(s + LAT, 0, 8'h80, 1, 8'h00);
    repeat (LAT + 2) @(negedge clk);

    // Input changes after capture are ignored
    set_vec(8'h10, 8'h20, 8'h18, 8'h08);
    pulse_start(s);
    push_exp(s + LAT, 1, 8'h20, 2, 8'h18);
    repeat (AC + 2) @(negedge clk);
    set_vec(8'h7F, 8'h7F, 8'h7F, 8'h7F);
    repeat (LAT) @(negedge clk);

    // Restart mid-scan: only the second run reports
    set_vec(8'h38, 8'h40, 8'hC0, 8'h30);
    pulse_start(s);
    repeat (AC + 2) @(negedge clk);
    set_vec(8'hC0, 8'hB8, 8'hC8, 8'hB8);
    pulse_start(s2);
    push_exp(s2 + LAT, 1, 8'hB8, 3, 8'hB8);
    repeat (LAT + 2) @(negedge clk);

    // Restart on the finishing edge: valid must stay low
    set_vec(8'h80, 8'h00, 8'h80, 8'hB8);
    pulse_start(s);
    repeat (LAT - 2) @(negedge clk);
    pulse_start(s2);
    check("restart_on_final_edge", 32'(s2), 32'(s + LAT));
    check("no_valid_on_restart", 32'(bus.valid), 32'd0);
    push_exp(s2 + LAT, 0, 8'h80, 1, 8'h00);
    repeat (LAT + 2) @(negedge clk);

    // Async reset during WAIT, then start ignored while reset is high
    set_vec(8'h38, 8'h40, 8'hC0, 8'h30);
    pulse_start(s);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_zero("reset_in_wait");
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    check_zero("start_during_reset");

    // Async reset while holding a result
    pulse_start(s);
    push_exp(s + LAT, 1, 8'h40, 0, 8'h38);
    repeat (LAT + 1) @(negedge clk);
    check("valid_held", 32'(bus.valid), 32'd1);
    #2 reset = 1'b1;
    #1 check_zero("reset_in_done");
    @(negedge clk);
    reset = 1'b0;

    // Runner-up vector, also a clean run after reset
    set_vec(8'h40, 8'h48, 8'h38, 8'h44);
    pulse_start(s);
    push_exp(s + LAT, 1, 8'h48, 3, 8'h44);
    repeat (LAT + 2) @(negedge clk);

    check("results_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mlp_argmax.md
Name: mlp_argmax

Overview:
- Classification stage directly downstream of the layer-2 fully-connected array.
- Waits a fixed number of cycles after a start pulse, by which time the processing-element accumulators have finished.
- Captures the packed output vector in one cycle, then scans it sequentially, one element per cycle.
- Reports the index and value of the largest 8-bit float score, giving the network's predicted class.

Parameters:
- DATA_WIDTH, 8, width of one score (8-bit float: sign[7], exponent[6:3] with bias 7, mantissa[2:0]).
- OUTPUT_NODES, 387, number of scores in the input vector.
- ACC_CYCLES, 130, cycles from start to capture (must be >= 1); set to the layer's INPUT_NODES + PE latency.
- IDX_W (localparam), max(1, $clog2(OUTPUT_NODES)), width of the index outputs.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, single-cycle pulse coincident with the first input element being streamed into the layer.
- output_fc, input, DATA_WIDTH*OUTPUT_NODES, packed layer scores; element k is at [DATA_WIDTH*k +: DATA_WIDTH].
- busy, output, 1, high in WAIT and SCAN.
- valid, output, 1, result valid; held until the next start or reset.
- max_index, output, IDX_W, index of the maximum score.
- max_value, output, DATA_WIDTH, the maximum score.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, valid=0, max_index=0, max_value=0; counters and captured vector cleared.
- States and transitions:
  - IDLE --start--> WAIT, with cnt = ACC_CYCLES-1.
  - WAIT: cnt decrements every edge. On the edge where cnt==0, capture output_fc into an internal register, set idx=0, go to SCAN.
  - SCAN: each edge compares captured element idx, then idx++. The edge that processes idx==OUTPUT_NODES-1 goes to DONE and sets valid=1.
  - DONE --start--> WAIT, with valid cleared on that edge.
- Latency: valid rises ACC_CYCLES+OUTPUT_NODES edges after the start edge.
- Once captured, changes on output_fc do not affect the running scan.
- Compare key:
  - Zero (exp==0 and mant==0, either sign) maps to 8'h80.
  - Otherwise, sign=0 maps to {1,bits[6:0]}; sign=1 maps to ~bits.
  - Elements are compared as unsigned keys, so +0 == -0 and negatives order correctly.
- Element 0 unconditionally initialises best.
- A later element replaces best only if its key is strictly greater. Ties go to the lowest index.
- max_index and max_value update only on the valid-rising edge; they hold the previous result while busy.
- start while in WAIT or SCAN aborts and restarts: cnt reloads and the partial best is discarded.
- start on the same edge the scan would finish: the restart wins and valid stays 0.
- start in IDLE/DONE while valid=1: valid drops on that edge.
- OUTPUT_NODES==1: SCAN lasts one edge and max_index=0.

Optional Feature:
- Macro ARGMAX_RUNNER_UP_EN.
- Defined:
  - Adds outputs second_index (IDX_W) and second_value (DATA_WIDTH), reset 0.
  - Tracks the second-largest element with the same key and tie rules.
  - When the best is replaced, the old best becomes second.
  - Otherwise an element whose key is strictly greater than second's replaces second.
  - Both outputs update on the same edge as max_index.
  - With OUTPUT_NODES==1, second_index=0 and second_value=8'h00.
- Undefined: ports and logic are absent; primary behaviour is identical.

Test Plan:
- Set OUTPUT_NODES=4, ACC_CYCLES=3, and scores [0]=0x38, [1]=0x40, [2]=0xC0, [3]=0x30. Pulse start -> valid rises exactly 7 edges later; max_index=1, max_value=0x40; busy high for those 7 cycles.
- Scores all negative, [0]=0xC0, [1]=0xB8, [2]=0xC8, [3]=0xB8 -> max_index=1 (tie broken to the lower index), max_value=0xB8.
- Scores [0]=0x80 (-0), [1]=0x00 (+0), [2]=0x80, [3]=0xB8 -> max_index=0, max_value=0x80, confirming zeros compare equal.
- Change output_fc to all 0x7F two edges after capture -> result still comes from the captured data. Pulse start again mid-SCAN -> valid is not raised until 7 edges after the second start.
- Assert reset asynchronously in mid-WAIT and again with valid=1 -> all outputs read 0 immediately, state is IDLE, and start is ignored while reset is high.
- With ARGMAX_RUNNER_UP_EN and scores 0x40, 0x48, 0x38, 0x44 -> max_index=1, max_value=0x48; second_index=3, second_value=0x44.
